// File: rtl/ts_packet_collector.sv
// ts_packet_collector
//
// Collects a byte-serial MPEG-TS stream into whole packets for the CSA
// descrambler. The collector hunts for the 0x47 sync byte, gathers one packet
// with the first byte at the MSB of pkt_data, and latches the scrambling-
// control bits and PID. It then presents the packet on a valid/ready handshake
// and holds it stable until it is taken. Sync lock is tracked with a
// saturating count of consecutive packets that start on 0x47.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   byte_in     in   [7:0] stream byte
//   byte_valid  in   byte_in valid this cycle (no input backpressure)
//   pkt_data    out  [8*PKT_BYTES-1:0] packet, byte k at [W-1-8k -: 8]
//   pkt_valid   out  packet and header outputs valid and stable
//   pkt_ready   in   downstream accepts the packet
//   pkt_sc      out  [1:0] transport_scrambling_control (byte 3 [7:6])
//   pkt_pid     out  [12:0] PID ({byte 1 [4:0], byte 2})
//   locked      out  sync lock status
//   sync_loss   out  one-cycle pulse when lock is lost
//   overflow    out  one-cycle pulse when an input byte is dropped
module ts_packet_collector #(
  parameter int PKT_BYTES = 188,
  parameter int LOCK_PKTS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic [8*PKT_BYTES-1:0]   pkt_data,
  output logic                     pkt_valid,
  input  logic                     pkt_ready,
  output logic [1:0]               pkt_sc,
  output logic [12:0]              pkt_pid,
  output logic                     locked,
  output logic                     sync_loss,
  output logic                     overflow
);

  localparam int         DATA_W    = 8 * PKT_BYTES;
  localparam logic [7:0] SYNC_BYTE = 8'h47;
  localparam logic [7:0] LAST_IDX  = 8'(PKT_BYTES - 1);
  localparam logic [3:0] LOCK_CNT  = 4'(LOCK_PKTS);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2,
    EXPECT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          idx_q, idx_d;
  logic [3:0]          good_cnt_q, good_cnt_d;
  logic [DATA_W-1:0]   pkt_data_q, pkt_data_d;
  logic                pkt_valid_q, pkt_valid_d;
  logic [1:0]          pkt_sc_q, pkt_sc_d;
  logic [12:0]         pkt_pid_q, pkt_pid_d;
  logic                locked_q, locked_d;
  logic                sync_loss_q, sync_loss_d;
  logic                overflow_q, overflow_d;

  // Packet buffer is a shift register: after PKT_BYTES shifts the first byte
  // sits at the MSB, so no per-index write decode is needed.
  logic [DATA_W-1:0]   pkt_shift;
  logic                expect_step;

  assign pkt_shift = {pkt_data_q[DATA_W-9:0], byte_in};

  // Next-state and next-output computation for the collector FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    good_cnt_d  = good_cnt_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = pkt_valid_q;
    pkt_sc_d    = pkt_sc_q;
    pkt_pid_d   = pkt_pid_q;
    sync_loss_d = 1'b0;
    overflow_d  = 1'b0;
    expect_step = 1'b0;

    case (state_q)
      HUNT: begin
        if (byte_valid && (byte_in == SYNC_BYTE)) begin
          pkt_data_d = pkt_shift;
          idx_d      = 8'd1;
          good_cnt_d = 4'd1;
          state_d    = COLLECT;
        end else begin
          state_d = HUNT;
        end
      end
      COLLECT: begin
        if (byte_valid) begin
          pkt_data_d = pkt_shift;
          idx_d      = idx_q + 8'd1;
          if (idx_q == LAST_IDX) begin
            // Header fields are taken from the buffer as it will be after
            // this final shift, i.e. with byte 0 at the MSB.
            pkt_pid_d   = {pkt_shift[DATA_W-12 -: 5], pkt_shift[DATA_W-17 -: 8]};
            pkt_sc_d    = pkt_shift[DATA_W-25 -: 2];
            pkt_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      HOLD: begin
        if (pkt_ready) begin
          // A byte on the handshake cycle is treated as the first byte
          // after the packet, so back-to-back packets lose nothing.
          pkt_valid_d = 1'b0;
          state_d     = EXPECT;
          expect_step = byte_valid;
        end else begin
          overflow_d = byte_valid;
          state_d    = HOLD;
        end
      end
      EXPECT: begin
        expect_step = byte_valid;
      end
      default: begin
        state_d = HUNT;
      end
    endcase

    if (expect_step) begin
      if (byte_in == SYNC_BYTE) begin
        good_cnt_d = (good_cnt_q < LOCK_CNT) ? (good_cnt_q + 4'd1) : LOCK_CNT;
        pkt_data_d = pkt_shift;
        idx_d      = 8'd1;
        state_d    = COLLECT;
      end else begin
        good_cnt_d  = 4'd0;
        sync_loss_d = locked_q;
        state_d     = HUNT;
      end
    end else begin
      sync_loss_d = 1'b0;
    end

    locked_d = (good_cnt_d == LOCK_CNT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      idx_q       <= 8'd0;
      good_cnt_q  <= 4'd0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      pkt_sc_q    <= 2'd0;
      pkt_pid_q   <= 13'd0;
      locked_q    <= 1'b0;
      sync_loss_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      good_cnt_q  <= good_cnt_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_sc_q    <= pkt_sc_d;
      pkt_pid_q   <= pkt_pid_d;
      locked_q    <= locked_d;
      sync_loss_q <= sync_loss_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pkt_data  = pkt_data_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_sc    = pkt_sc_q;
  assign pkt_pid   = pkt_pid_q;
  assign locked    = locked_q;
  assign sync_loss = sync_loss_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/ts_packet_collector.md
# ts_packet_collector

Upstream feeder for the CSA descrambler. It turns a byte-serial MPEG-TS stream into whole 188-byte packets on the wide packet bus the descrambler consumes, with the first byte at the MSB. It finds and tracks the 0x47 sync byte and extracts the header fields the key-selection logic needs: the scrambling-control bits and the PID. It hands each packet downstream over a valid/ready handshake and holds it stable until it is taken.

## Interface
Parameters:
- PKT_BYTES, 188, bytes per TS packet. Fixed by the descrambler bus width; do not override.
- LOCK_PKTS, 3, consecutive good sync bytes needed to assert locked. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid this cycle. There is no backpressure on the input side.
- pkt_data  out  1504  assembled packet. Byte k (k=0 is the sync byte) is at bits [1503-8k : 1496-8k].
- pkt_valid  out  1  pkt_data and the header outputs are valid and stable.
- pkt_ready  in  1  downstream accepts the packet.
- pkt_sc  out  2  transport_scrambling_control, byte 3 bits [7:6]. 10 selects even CW, 11 selects odd CW, 0x means clear.
- pkt_pid  out  13  PID: byte 1 bits [4:0] concatenated with byte 2.
- locked  out  1  sync lock status.
- sync_loss  out  1  one-cycle pulse when lock is lost.
- overflow  out  1  one-cycle pulse when an input byte is dropped.

## Operation
States: HUNT, COLLECT, HOLD, EXPECT.

- **HUNT:** discard every valid byte except 0x47. On a valid 0x47:
  - store it as byte 0 and set idx=1;
  - go to COLLECT.
- **COLLECT:** each valid byte is stored at index idx and idx increments.
  - Bytes are not checked for 0x47 here.
  - On storing byte 187: latch pkt_sc and pkt_pid from the stored bytes, assert pkt_valid, go to HOLD.
- **HOLD:** pkt_valid=1 and all outputs are frozen.
  - On pkt_valid && pkt_ready: transfer, go to EXPECT.
  - A valid byte arriving in HOLD without a same-cycle transfer is dropped, overflow pulses, and the state stays HOLD.
  - A valid byte arriving in the same cycle as the transfer is processed exactly as in EXPECT, with no overflow.
- **EXPECT:** wait for the next valid byte.
  - If it is 0x47: good_cnt = min(good_cnt+1, LOCK_PKTS), store it as byte 0, idx=1, go to COLLECT.
  - Otherwise: discard it, good_cnt=0, go to HUNT. If locked was 1, clear it and pulse sync_loss.
- good_cnt is a 4-bit saturating counter. It becomes 1 on the first 0x47 taken in HUNT.
- locked=1 whenever good_cnt==LOCK_PKTS.
- Packets are delivered whether or not locked is set; locked is status only.
- idx is 8 bits. It resets to 0 and is set to 1 on every packet start.

## Timing
- Reset values:
  - state=HUNT, idx=0, good_cnt=0;
  - pkt_valid=0, pkt_data=0, pkt_sc=0, pkt_pid=0;
  - locked=0, sync_loss=0, overflow=0.
- Latency: if byte 187 is accepted at edge N, pkt_valid, pkt_sc and pkt_pid are high/valid after edge N and pkt_data is complete.
- pkt_valid falls on the edge after the handshake.
- Back-to-back packets: the sync byte of the next packet may arrive on the handshake cycle; that packet is then available 188 accepted bytes later.
- Gaps in byte_valid (byte_valid=0) do not advance idx and do not affect sync.
- sync_loss and overflow are each exactly one cycle wide.
- Reset mid-packet discards the partial packet and any held packet immediately.

## Test plan
- Reset, then 5 contiguous valid packets, each starting with 0x47, pkt_ready tied 1:
  - exactly 5 pkt_valid handshakes, data bit-exact;
  - locked rises after the 3rd packet's sync byte is taken in EXPECT.
- 3 garbage bytes (0x00, 0x12, 0xFF), then a packet with header bytes 47 1F FF D0:
  - garbage is ignored;
  - pkt_pid=0x1FFF, pkt_sc=2'b11.
- Locked stream, then the 4th packet starts with 0x48:
  - sync_loss pulses one cycle, locked=0;
  - no packet is emitted until the next 0x47, which is delivered;
  - locked returns after 3 more good packets.
- Hold pkt_ready=0 for 10 cycles after a packet completes while 4 valid bytes arrive:
  - 4 overflow pulses, pkt_data unchanged;
  - when ready rises, the next 0x47 restarts collection.
- Sync byte of packet 2 presented on the same cycle as packet 1's handshake:
  - no overflow;
  - packet 2 is delivered intact.
- Assert rst_n low at byte 100 of a packet:
  - all outputs go to their reset values immediately;
  - the next 0x47 starts a fresh packet.
